// File: rtl/gpu_pkg.sv
// gpu_pkg
// Encodings and default widths shared by the core pipeline blocks.
//   scheduler_state_t : state broadcast by the per-core warp scheduler
//   fetcher_state_t   : state exported by warp_fetcher
//   DEFAULT_*_BITS    : default program-memory address/data widths
package gpu_pkg;

    typedef enum logic [1:0] {
        SCHED_IDLE       = 2'b00,
        SCHED_FETCHING   = 2'b01,
        SCHED_PROCESSING = 2'b10,
        SCHED_WAITING    = 2'b11
    } scheduler_state_t;

    typedef enum logic [2:0] {
        FETCHER_IDLE     = 3'b000,
        FETCHER_FETCHING = 3'b001,
        FETCHER_FETCHED  = 3'b010
    } fetcher_state_t;

    localparam int DEFAULT_ADDR_BITS = 8;
    localparam int DEFAULT_DATA_BITS = 16;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer
// One-entry-per-warp instruction buffer tagged by PC.
//   clk, reset        : clock, synchronous active-low reset (clears valid bits)
//   clear             : invalidate every entry; wins over a same-cycle write
//   lookup_warp/pc    : combinational lookup -> lookup_hit, lookup_data
//   wr_en/warp/pc/data: single write port, fills entry[wr_warp]
module fetch_buffer
    import gpu_pkg::*;
#(
    parameter int NUM_WARPS = 2,
    parameter int WID_BITS  = 1,
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [WID_BITS-1:0]  lookup_warp,
    input  logic [ADDR_BITS-1:0] lookup_pc,
    output logic                 lookup_hit,
    output logic [DATA_BITS-1:0] lookup_data,
    input  logic                 wr_en,
    input  logic [WID_BITS-1:0]  wr_warp,
    input  logic [ADDR_BITS-1:0] wr_pc,
    input  logic [DATA_BITS-1:0] wr_data
);

    logic [NUM_WARPS-1:0] valid_q, valid_d;
    logic [ADDR_BITS-1:0] tag_q  [NUM_WARPS];
    logic [ADDR_BITS-1:0] tag_d  [NUM_WARPS];
    logic [DATA_BITS-1:0] data_q [NUM_WARPS];
    logic [DATA_BITS-1:0] data_d [NUM_WARPS];

    assign lookup_hit  = valid_q[lookup_warp] && (tag_q[lookup_warp] == lookup_pc);
    assign lookup_data = data_q[lookup_warp];

    // Clear is applied after the write so a flush in the fill cycle wins.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d[wr_warp] = 1'b1;
            tag_d[wr_warp]   = wr_pc;
            data_d[wr_warp]  = wr_data;
        end
        if (clear) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tags and data are meaningless without their valid bit, so no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/warp_fetcher.sv
// warp_fetcher
// Instruction-fetch stage between the warp scheduler and program memory.
// Re-fetches of the same PC by the same warp are served from fetch_buffer.
//   clk, reset          : clock, synchronous active-low reset
//   scheduler_state     : fetch requested while it equals SCHED_FETCHING
//   warp_id, pc         : warp being fetched and its PC
//   flush               : invalidate the instruction buffer
//   mem_read_*          : program-memory valid/ready read channel
//   fetcher_state       : IDLE / FETCHING / FETCHED
//   instruction(_ready) : fetched word, ready high throughout FETCHED
module warp_fetcher
    import gpu_pkg::*;
#(
    parameter int MAX_WARPS_PER_CORE    = 2,
    parameter int WARP_ID_BITS          = (MAX_WARPS_PER_CORE > 1) ? $clog2(MAX_WARPS_PER_CORE) : 1,
    parameter int PROGRAM_MEM_ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int PROGRAM_MEM_DATA_BITS = DEFAULT_DATA_BITS
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [1:0]                       scheduler_state,
    input  logic [WARP_ID_BITS-1:0]          warp_id,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] pc,
    input  logic                             flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic                             instruction_ready
);

    fetcher_state_t                   state_q, state_d;
    logic [WARP_ID_BITS-1:0]          req_warp_q, req_warp_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] req_pc_q, req_pc_d;
    logic                             mem_read_valid_q, mem_read_valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address_q, mem_read_address_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instruction_q, instruction_d;
    logic                             instruction_ready_q, instruction_ready_d;
    logic                             stale_q, stale_d;

    logic                             fetch_req;
    logic                             lookup_hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] lookup_data;
    logic                             buf_wr_en;

    assign fetch_req = (scheduler_state == SCHED_FETCHING);

    fetch_buffer #(
        .NUM_WARPS (MAX_WARPS_PER_CORE),
        .WID_BITS  (WARP_ID_BITS),
        .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
        .DATA_BITS (PROGRAM_MEM_DATA_BITS)
    ) u_fetch_buffer (
        .clk         (clk),
        .reset       (reset),
        .clear       (flush),
        .lookup_warp (warp_id),
        .lookup_pc   (pc),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data),
        .wr_en       (buf_wr_en),
        .wr_warp     (req_warp_q),
        .wr_pc       (req_pc_q),
        .wr_data     (mem_read_data)
    );

    always_comb begin
        state_d             = state_q;
        req_warp_d          = req_warp_q;
        req_pc_d            = req_pc_q;
        mem_read_valid_d    = mem_read_valid_q;
        mem_read_address_d  = mem_read_address_q;
        instruction_d       = instruction_q;
        instruction_ready_d = instruction_ready_q;
        stale_d             = stale_q;
        buf_wr_en           = 1'b0;

        unique case (state_q)
            FETCHER_IDLE: begin
                if (fetch_req) begin
                    req_warp_d = warp_id;
                    req_pc_d   = pc;
                    // A hit on an entry being flushed this same edge is treated as a miss.
                    if (lookup_hit && !flush) begin
                        instruction_d       = lookup_data;
                        instruction_ready_d = 1'b1;
                        state_d             = FETCHER_FETCHED;
                    end else begin
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d = pc;
                        state_d            = FETCHER_FETCHING;
                    end
                end
            end

            FETCHER_FETCHING: begin
                if (flush) begin
                    stale_d = 1'b1;
                end
                if (mem_read_ready) begin
                    mem_read_valid_d = 1'b0;
                    // A flush seen anytime during the request makes the returned word suspect.
                    if (stale_q || flush) begin
                        state_d = FETCHER_IDLE;
                    end else begin
                        buf_wr_en           = 1'b1;
                        instruction_d       = mem_read_data;
                        instruction_ready_d = 1'b1;
                        state_d             = FETCHER_FETCHED;
                    end
                end
            end

            FETCHER_FETCHED: begin
                if (!fetch_req || (warp_id != req_warp_q) || (pc != req_pc_q)) begin
                    instruction_ready_d = 1'b0;
                    state_d             = FETCHER_IDLE;
                end
            end

            default: begin
                instruction_ready_d = 1'b0;
                mem_read_valid_d    = 1'b0;
                state_d             = FETCHER_IDLE;
            end
        endcase

        if (state_d == FETCHER_IDLE) begin
            stale_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q             <= FETCHER_IDLE;
            req_warp_q          <= '0;
            req_pc_q            <= '0;
            mem_read_valid_q    <= 1'b0;
            mem_read_address_q  <= '0;
            instruction_q       <= '0;
            instruction_ready_q <= 1'b0;
            stale_q             <= 1'b0;
        end else begin
            state_q             <= state_d;
            req_warp_q          <= req_warp_d;
            req_pc_q            <= req_pc_d;
            mem_read_valid_q    <= mem_read_valid_d;
            mem_read_address_q  <= mem_read_address_d;
            instruction_q       <= instruction_d;
            instruction_ready_q <= instruction_ready_d;
            stale_q             <= stale_d;
        end
    end

    assign fetcher_state     = state_q;
    assign mem_read_valid    = mem_read_valid_q;
    assign mem_read_address  = mem_read_address_q;
    assign instruction       = instruction_q;
    assign instruction_ready = instruction_ready_q;

endmodule

// File: tb/tb_warp_fetcher.sv
// tb_warp_fetcher
// Directed bench for warp_fetcher: inputs change 1ns after a rising edge and
// outputs are checked at that same point, well away from the next edge.
module tb_warp_fetcher;

    logic        clk;
    logic        reset;
    logic [1:0]  scheduler_state;
    logic [0:0]  warp_id;
    logic [7:0]  pc;
    logic        flush;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;
    logic        instruction_ready;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_FETCH = 2'b01;
    localparam logic [1:0] S_PROC = 2'b10;
    localparam logic [2:0] F_IDLE = 3'b000;
    localparam logic [2:0] F_FETCHING = 3'b001;
    localparam logic [2:0] F_FETCHED = 3'b010;

    warp_fetcher dut (
        .clk               (clk),
        .reset             (reset),
        .scheduler_state   (scheduler_state),
        .warp_id           (warp_id),
        .pc                (pc),
        .flush             (flush),
        .mem_read_valid    (mem_read_valid),
        .mem_read_address  (mem_read_address),
        .mem_read_ready    (mem_read_ready),
        .mem_read_data     (mem_read_data),
        .fetcher_state     (fetcher_state),
        .instruction       (instruction),
        .instruction_ready (instruction_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle 1ns past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] sched, input logic [0:0] wid,
                                 input logic [7:0] p, input logic fl,
                                 input logic rdy, input logic [15:0] data);
        scheduler_state = sched;
        warp_id         = wid;
        pc              = p;
        flush           = fl;
        mem_read_ready  = rdy;
        mem_read_data   = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Full view of the fetcher's outputs against one expected snapshot.
    task automatic checkAll(input string tag, input logic [2:0] st, input logic mv,
                            input logic [7:0] addr, input logic [15:0] instr,
                            input logic rdy);
        checkOutput({tag, ".state"}, 32'(fetcher_state), 32'(st));
        checkOutput({tag, ".mem_valid"}, 32'(mem_read_valid), 32'(mv));
        checkOutput({tag, ".mem_addr"}, 32'(mem_read_address), 32'(addr));
        checkOutput({tag, ".instr"}, 32'(instruction), 32'(instr));
        checkOutput({tag, ".ready"}, 32'(instruction_ready), 32'(rdy));
    endtask

    initial begin
        $display("[TB] warp_fetcher directed test start");
        reset = 1'b0;
        applyStimulus(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000);
        step();
        step();
        checkAll("reset", F_IDLE, 1'b0, 8'h00, 16'h0000, 1'b0);
        reset = 1'b1;

        // Cold miss: warp 0, pc 0, memory answers after three request cycles.
        applyStimulus(S_FETCH, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000);
        step();
        checkAll("miss0.c1", F_FETCHING, 1'b1, 8'h00, 16'h0000, 1'b0);
        step();
        checkAll("miss0.c2", F_FETCHING, 1'b1, 8'h00, 16'h0000, 1'b0);
        step();
        checkAll("miss0.c3", F_FETCHING, 1'b1, 8'h00, 16'h0000, 1'b0);
        applyStimulus(S_FETCH, 1'b0, 8'h00, 1'b0, 1'b1, 16'hA5A5);
        step();
        checkAll("miss0.fill", F_FETCHED, 1'b0, 8'h00, 16'hA5A5, 1'b1);
        applyStimulus(S_FETCH, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000);
        step();
        checkAll("miss0.hold", F_FETCHED, 1'b0, 8'h00, 16'hA5A5, 1'b1);
        applyStimulus(S_PROC, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000);
        step();
        checkAll("miss0.idle", F_IDLE, 1'b0, 8'h00, 16'hA5A5, 1'b0);

        // Hit: same warp and pc, one-cycle latency, no memory request.
        applyStimulus(S_FETCH, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000);
        step();
        checkAll("hit0", F_FETCHED, 1'b0, 8'h00, 16'hA5A5, 1'b1);
        applyStimulus(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000);
        step();
        checkAll("hit0.idle", F_IDLE, 1'b0, 8'h00, 16'hA5A5, 1'b0);

        // Per-warp isolation: warp 1 at pc 0 misses and fills its own entry.
        applyStimulus(S_FETCH, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000);
        step();
        checkAll("miss1", F_FETCHING, 1'b1, 8'h00, 16'hA5A5, 1'b0);
        applyStimulus(S_FETCH, 1'b1, 8'h00, 1'b0, 1'b1, 16'h1234);
        step();
        checkAll("miss1.fill", F_FETCHED, 1'b0, 8'h00, 16'h1234, 1'b1);
        applyStimulus(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000);
        step();
        applyStimulus(S_FETCH, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000);
        step();
        checkAll("hit0.again", F_FETCHED, 1'b0, 8'h00, 16'hA5A5, 1'b1);
        applyStimulus(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000);
        step();
        applyStimulus(S_FETCH, 1'b0, 8'h01, 1'b0, 1'b0, 16'h0000);
        step();
        checkAll("miss0.pc1", F_FETCHING, 1'b1, 8'h01, 16'hA5A5, 1'b0);
        applyStimulus(S_FETCH, 1'b0, 8'h01, 1'b0, 1'b1, 16'h0BEE);
        step();
        checkAll("miss0.pc1.fill", F_FETCHED, 1'b0, 8'h01, 16'h0BEE, 1'b1);

        // Warp switch while FETCHED: scheduler stays FETCHING on another warp.
        applyStimulus(S_FETCH, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000);
        step();
        checkAll("switch.idle", F_IDLE, 1'b0, 8'h01, 16'h0BEE, 1'b0);
        step();
        checkAll("switch.hit1", F_FETCHED, 1'b0, 8'h01, 16'h1234, 1'b1);
        applyStimulus(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000);
        step();

        // Flush in the second FETCHING cycle discards the fill.
        applyStimulus(S_FETCH, 1'b0, 8'h10, 1'b0, 1'b0, 16'h0000);
        step();
        checkAll("flush.c1", F_FETCHING, 1'b1, 8'h10, 16'h1234, 1'b0);
        applyStimulus(S_FETCH, 1'b0, 8'h10, 1'b1, 1'b0, 16'h0000);
        step();
        checkAll("flush.c2", F_FETCHING, 1'b1, 8'h10, 16'h1234, 1'b0);
        applyStimulus(S_FETCH, 1'b0, 8'h10, 1'b0, 1'b1, 16'hDEAD);
        step();
        checkAll("flush.drop", F_IDLE, 1'b0, 8'h10, 16'h1234, 1'b0);
        applyStimulus(S_FETCH, 1'b0, 8'h10, 1'b0, 1'b0, 16'h0000);
        step();
        checkAll("flush.remiss", F_FETCHING, 1'b1, 8'h10, 16'h1234, 1'b0);
        applyStimulus(S_FETCH, 1'b0, 8'h10, 1'b0, 1'b1, 16'h5555);
        step();
        checkAll("flush.refill", F_FETCHED, 1'b0, 8'h10, 16'h5555, 1'b1);
        applyStimulus(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000);
        step();

        // The flush also invalidated warp 1's entry.
        applyStimulus(S_FETCH, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000);
        step();
        checkAll("flush.w1miss", F_FETCHING, 1'b1, 8'h00, 16'h5555, 1'b0);

        // Reset mid-request drops it; a late ready is ignored.
        reset = 1'b0;
        step();
        checkAll("rst.mid", F_IDLE, 1'b0, 8'h00, 16'h0000, 1'b0);
        reset = 1'b1;
        applyStimulus(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b1, 16'hFFFF);
        step();
        checkAll("rst.lateready", F_IDLE, 1'b0, 8'h00, 16'h0000, 1'b0);
        applyStimulus(S_FETCH, 1'b0, 8'h10, 1'b0, 1'b0, 16'h0000);
        step();
        checkAll("rst.miss", F_FETCHING, 1'b1, 8'h10, 16'h0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
